sub16_serial: RTL and testbench

Multi-cycle bit-serial subtractor. Computes d = a - b as a + ~b + 1 over several clocks, trading latency for a narrow datapath. It is the inverse operation to the combinational 16-bit adder in the arith library. It sits beside the adder as a low-area arithmetic unit and is driven through valid/ready handshakes on both sides.

---
 rtl/sub16_serial.sv | 143 ++++++++++++++
 tb/tb_sub16_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sub16_serial.sv
// Bit-serial subtractor: d = a - b computed as a + ~b + 1, BITS_PER_CYCLE bits per clock.
// Define SUB16_SERIAL_FLAGS_EN to add the registered zr/ng status outputs.
module sub16_serial #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow
`ifdef SUB16_SERIAL_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);

  localparam int K     = BITS_PER_CYCLE;
  localparam int N     = WIDTH / K;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (!(K == 1 || K == 2 || K == 4 || K == 8) || (WIDTH % K) != 0 || N < 2) begin : g_bad_cfg
      $error("sub16_serial: BITS_PER_CYCLE must be 1/2/4/8 and divide WIDTH into at least two slices");
    end
  endgenerate

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [CNT_W-1:0] count_reg;
  logic             carry_reg;
  logic             borrow_reg;
  logic             armed_reg;

  logic [K:0]       chain;
  logic [K-1:0]     sum_bits;
  logic             accept;
  logic             release_out;
  logic             last_slice;

  // armed_reg keeps in_ready low until the first edge after reset release
  assign in_ready    = armed_reg && (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign d           = res_reg;
  assign borrow      = borrow_reg;
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last_slice  = (state_reg == RUN) && (count_reg == LAST);

  // Ripple slice adder over the low K bits of the operand shift registers
  assign chain[0] = carry_reg;
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_fa
      assign sum_bits[gi]  = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
      assign chain[gi + 1] = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (count_reg == LAST) state_next = DONE;
      DONE:    if (release_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      armed_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      count_reg  <= '0;
      carry_reg  <= 1'b1;
      borrow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= ~b;
            carry_reg <= 1'b1;
            count_reg <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> K;
          b_reg     <= b_reg >> K;
          res_reg   <= {sum_bits, res_reg[WIDTH-1:K]};
          carry_reg <= chain[K];
          count_reg <= count_reg + CNT_W'(1);
          if (last_slice) borrow_reg <= ~chain[K];
        end
        default: ;
      endcase
    end
  end

`ifdef SUB16_SERIAL_FLAGS_EN
  logic any_one_reg;
  logic zr_reg;
  logic ng_reg;

  assign zr = zr_reg;
  assign ng = ng_reg;

  // Zero detect accumulates one slice at a time instead of a WIDTH-wide reduction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_one_reg <= 1'b0;
      zr_reg      <= 1'b0;
      ng_reg      <= 1'b0;
    end else begin
      if (accept) begin
        any_one_reg <= 1'b0;
      end else if (state_reg == RUN) begin
        any_one_reg <= any_one_reg | (|sum_bits);
      end
      if (last_slice) begin
        zr_reg <= ~(any_one_reg | (|sum_bits));
        ng_reg <= sum_bits[K-1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sub16_serial.sv
// Directed bench for sub16_serial: one instance at 1 bit/cycle, one at 4 bits/cycle.
module tb_sub16_serial;

  logic        clk;
  logic        rst_n;

  logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, borrow_1;
  logic [15:0] a_1, b_1, d_1;
  logic        in_valid_4, in_ready_4, out_valid_4, out_ready_4, borrow_4;
  logic [15:0] a_4, b_4, d_4;
`ifdef SUB16_SERIAL_FLAGS_EN
  logic        zr_1, ng_1, zr_4, ng_4;
`endif

  int n_vec = 0;
  int n_bad = 0;

  sub16_serial #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_1),
    .in_ready  (in_ready_1),
    .a         (a_1),
    .b         (b_1),
    .out_valid (out_valid_1),
    .out_ready (out_ready_1),
    .d         (d_1),
    .borrow    (borrow_1)
`ifdef SUB16_SERIAL_FLAGS_EN
    ,
    .zr        (zr_1),
    .ng        (ng_1)
`endif
  );

  sub16_serial #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_4),
    .in_ready  (in_ready_4),
    .a         (a_4),
    .b         (b_4),
    .out_valid (out_valid_4),
    .out_ready (out_ready_4),
    .d         (d_4),
    .borrow    (borrow_4)
`ifdef SUB16_SERIAL_FLAGS_EN
    ,
    .zr        (zr_4),
    .ng        (ng_4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_in_ready(input int sel);
    return (sel == 1) ? in_ready_1 : in_ready_4;
  endfunction

  function automatic logic cur_out_valid(input int sel);
    return (sel == 1) ? out_valid_1 : out_valid_4;
  endfunction

  function automatic logic [15:0] cur_d(input int sel);
    return (sel == 1) ? d_1 : d_4;
  endfunction

  function automatic logic cur_borrow(input int sel);
    return (sel == 1) ? borrow_1 : borrow_4;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [15:0] av, input logic [15:0] bv);
    if (sel == 1) begin
      in_valid_1 = v; a_1 = av; b_1 = bv;
    end else begin
      in_valid_4 = v; a_4 = av; b_4 = bv;
    end
  endtask

  task automatic set_out_ready(input int sel, input logic v);
    if (sel == 1) out_ready_1 = v;
    else          out_ready_4 = v;
  endtask

  // One full transaction; called #1 after a rising edge with the unit idle.
  task automatic op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                    input logic [15:0] ed, input logic eb, input int elat, input string tag);
    int lat;
    chk({tag, "_in_ready_idle"}, cur_in_ready(sel), 1);
    drive(sel, 1'b1, av, bv);
    @(posedge clk); #1;
    // scramble operands after acceptance: must not affect the result
    drive(sel, 1'b0, ~av, ~bv);
    chk({tag, "_in_ready_fall"}, cur_in_ready(sel), 0);
    lat = 0;
    while (!cur_out_valid(sel) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_d"}, cur_d(sel), ed);
    chk({tag, "_borrow"}, cur_borrow(sel), eb);
`ifdef SUB16_SERIAL_FLAGS_EN
    chk({tag, "_zr"}, (sel == 1) ? zr_1 : zr_4, (ed == 16'h0000));
    chk({tag, "_ng"}, (sel == 1) ? ng_1 : ng_4, ed[15]);
`endif
    set_out_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_out_ready(sel, 1'b0);
    chk({tag, "_out_valid_drop"}, cur_out_valid(sel), 0);
    chk({tag, "_in_ready_rise"}, cur_in_ready(sel), 1);
    $display("op %s: %h - %h -> d=%h borrow=%b latency=%0d", tag, av, bv, cur_d(sel), cur_borrow(sel), lat);
  endtask

  initial begin
    int lat;
    int hits;

    in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; out_ready_1 = 1'b0;
    in_valid_4 = 1'b0; a_4 = '0; b_4 = '0; out_ready_4 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_1, 0);
    chk("rst_out_valid", out_valid_1, 0);
    chk("rst_d", d_1, 16'h0000);
    chk("rst_borrow", borrow_1, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", in_ready_1, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", in_ready_1, 1);
    $display("reset: in_ready=%b out_valid=%b d=%h", in_ready_1, out_valid_1, d_1);

    op(1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16, "b1_zero");
    op(1, 16'h0003, 16'h0001, 16'h0002, 1'b0, 16, "b1_3m1");
    op(1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 16, "b1_0m1");
    op(1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 16, "b1_8000m1");
    op(1, 16'hFFFE, 16'hFFFE, 16'h0000, 1'b0, 16, "b1_eq");

    // Backpressure with a competing request held during RUN and DONE
    chk("bp_in_ready_idle", in_ready_1, 1);
    a_1 = 16'h00F0; b_1 = 16'h000F; in_valid_1 = 1'b1;
    @(posedge clk); #1;
    a_1 = 16'h5555; b_1 = 16'h0AAA;
    lat = 0;
    hits = 0;
    while (!out_valid_1 && lat < 100) begin
      if (in_ready_1) hits++;
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 16);
    for (int i = 0; i < 5; i++) begin
      chk("bp_d_hold", d_1, 16'h00E1);
      chk("bp_borrow_hold", borrow_1, 0);
      chk("bp_valid_hold", out_valid_1, 1);
      if (in_ready_1) hits++;
      @(posedge clk); #1;
    end
    chk("bp_no_accept_busy", hits, 0);
    in_valid_1 = 1'b0;
    out_ready_1 = 1'b1;
    @(posedge clk); #1;
    out_ready_1 = 1'b0;
    chk("bp_out_valid_drop", out_valid_1, 0);
    chk("bp_in_ready_rise", in_ready_1, 1);
    $display("backpressure: d=%h held 5 cycles, busy accepts=%0d", d_1, hits);

    // Reset in the middle of RUN discards the operation
    a_1 = 16'h1111; b_1 = 16'h0001; in_valid_1 = 1'b1;
    @(posedge clk); #1;
    in_valid_1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid_1, 0);
    chk("mid_rst_in_ready", in_ready_1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hits = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid_1) hits++;
    end
    chk("mid_rst_no_out_valid", hits, 0);
    chk("mid_rst_in_ready_after", in_ready_1, 1);
    $display("mid-run reset: out_valid pulses=%0d", hits);
    op(1, 16'h1234, 16'h0234, 16'h1000, 1'b0, 16, "b1_after_rst");

    op(4, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, "b4_zero");
    op(4, 16'h0003, 16'h0001, 16'h0002, 1'b0, 4, "b4_3m1");
    op(4, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 4, "b4_0m1");
    op(4, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 4, "b4_8000m1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
